// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays change_in out as $50/$10/$5/$1 coins over a coin_valid/coin_ack handshake.
// Optional finite per-denomination stock with refill and FAULT state: define COIN_STOCK_EN.
module change_dispenser #(
  parameter logic [3:0] STOCK_INIT = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] change_in,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       busy,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic [6:0] remaining,
  output logic [6:0] coin_count,
  output logic       done,
  output logic       fault
);

`ifdef COIN_STOCK_EN
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;
`endif

  state_t     state, state_next;
  logic [6:0] remaining_next, coin_count_next;
  logic [1:0] coin_type_next, sel_type;
  logic [3:0] stock_ok, usable;
  logic       sel_ok, ack_take;

  function automatic logic [6:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    coin_value = 7'd1;
      2'd1:    coin_value = 7'd5;
      2'd2:    coin_value = 7'd10;
      default: coin_value = 7'd50;
    endcase
  endfunction

`ifdef COIN_STOCK_EN
  logic [3:0] stock [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
    end else if (refill && state == IDLE) begin
      for (int unsigned i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
    end else if (ack_take) begin
      stock[coin_type] <= stock[coin_type] - 4'd1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) stock_ok[i] = (stock[i] != 4'd0);
  end
`else
  logic unused_refill;
  assign unused_refill = refill;
  assign stock_ok      = '1;
`endif

  // Largest denomination that fits the amount owed and is in stock.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      usable[i] = stock_ok[i] && (coin_value(2'(i)) <= remaining);
    sel_ok   = |usable;
    sel_type = 2'd0;
    if (usable[3])      sel_type = 2'd3;
    else if (usable[2]) sel_type = 2'd2;
    else if (usable[1]) sel_type = 2'd1;
  end

  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    coin_count_next = coin_count;
    coin_type_next  = coin_type;
    busy            = 1'b0;
    coin_valid      = 1'b0;
    done            = 1'b0;
    fault           = 1'b0;
    ack_take        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_next  = change_in;
          coin_count_next = '0;
          state_next      = (change_in == 7'd0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        busy = 1'b1;
        if (sel_ok) begin
          coin_type_next = sel_type;
          state_next     = OFFER;
        end
`ifdef COIN_STOCK_EN
        else begin
          state_next = FAULT;
        end
`endif
      end
      OFFER: begin
        busy       = 1'b1;
        coin_valid = 1'b1;
        if (coin_ack) begin
          ack_take        = 1'b1;
          remaining_next  = remaining - coin_value(coin_type);
          coin_count_next = coin_count + 7'd1;
          state_next      = (remaining_next == 7'd0) ? DONE : SELECT;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
`ifdef COIN_STOCK_EN
      FAULT: begin
        busy  = 1'b1;
        fault = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_count <= '0;
      coin_type  <= '0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      coin_count <= coin_count_next;
      coin_type  <= coin_type_next;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table plus reset, busy-start and stock corner cases.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       reset, start, coin_ack, refill;
  logic [6:0] change_in;
  logic       busy, coin_valid, done, fault;
  logic [1:0] coin_type;
  logic [6:0] remaining, coin_count;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .change_in(change_in),
    .coin_ack(coin_ack), .refill(refill), .busy(busy), .coin_valid(coin_valid),
    .coin_type(coin_type), .remaining(remaining), .coin_count(coin_count),
    .done(done), .fault(fault)
  );

`ifdef COIN_STOCK_EN
  logic       start2, ack2, busy2, valid2, done2, fault2;
  logic [1:0] type2;
  logic [6:0] rem2, count2;

  change_dispenser #(.STOCK_INIT(4'd2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .change_in(change_in),
    .coin_ack(ack2), .refill(1'b0), .busy(busy2), .coin_valid(valid2),
    .coin_type(type2), .remaining(rem2), .coin_count(count2),
    .done(done2), .fault(fault2)
  );
`endif

  typedef struct {
    logic [6:0] amt;
    int         ack_delay;
    int         exp_count;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_greedy(input int amt);
    int a = amt;
    while (a > 0) begin
      if (a >= 50)      begin exp_q.push_back(2'd3); a -= 50; end
      else if (a >= 10) begin exp_q.push_back(2'd2); a -= 10; end
      else if (a >= 5)  begin exp_q.push_back(2'd1); a -= 5;  end
      else              begin exp_q.push_back(2'd0); a -= 1;  end
    end
  endtask

  task automatic start_req(input logic [6:0] amt);
    @(negedge clk);
    start = 1'b1; change_in = amt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Acks each offer after ack_delay cycles, pops expected coin types, checks completion.
  task automatic finish_run(input int exp_count, input int ack_delay, input bit zero_req);
    int waited = 0;
    int cycles = 0;
    bit seen_done = 1'b0;
    bit offering = 1'b0;
    logic [1:0] held = 2'd0;
    if (zero_req) check("zero_done_next_cycle", int'(done), 1);
    else          check("busy_after_start", int'(busy), 1);
    while (!seen_done && cycles < 400) begin
      coin_ack = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        check("done_busy_low", int'(busy), 0);
        check("done_remaining", int'(remaining), 0);
        check("done_coin_count", int'(coin_count), exp_count);
        check("coins_outstanding", exp_q.size(), 0);
      end else if (coin_valid) begin
        if (!offering) begin
          offering = 1'b1; waited = 0; held = coin_type;
        end else begin
          check("coin_type_stable", int'(coin_type), int'(held));
        end
        if (waited == ack_delay) begin
          if (exp_q.size() == 0) check("unexpected_coin", 1, 0);
          else                   check("coin_type", int'(coin_type), int'(exp_q.pop_front()));
          coin_ack = 1'b1;
          offering = 1'b0;
        end
        waited++;
      end
      @(negedge clk);
      cycles++;
    end
    coin_ack = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
    check("done_one_cycle", int'(done), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; coin_ack = 1'b0; refill = 1'b0; change_in = '0;
`ifdef COIN_STOCK_EN
    start2 = 1'b0; ack2 = 1'b0;
`endif
    vecs[0] = '{7'd68,  0, 6};
    vecs[1] = '{7'd0,   0, 0};
    vecs[2] = '{7'd10,  5, 1};
    vecs[3] = '{7'd127, 0, 7};
    vecs[4] = '{7'd99,  1, 10};
    vecs[5] = '{7'd4,   2, 4};
    vecs[6] = '{7'd16,  0, 3};
    vecs[7] = '{7'd55,  0, 2};

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_coin_type", int'(coin_type), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_coin_count", int'(coin_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push_greedy(int'(vecs[i].amt));
      start_req(vecs[i].amt);
      finish_run(vecs[i].exp_count, vecs[i].ack_delay, vecs[i].amt == 7'd0);
    end

    // Reset while a coin is on offer abandons it immediately.
    start_req(7'd55);
    n = 0;
    while (!coin_valid && n < 10) begin @(negedge clk); n++; end
    check("offer_seen_before_reset", int'(coin_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_coin_valid", int'(coin_valid), 0);
    check("midreset_remaining", int'(remaining), 0);
    check("midreset_coin_count", int'(coin_count), 0);
    @(negedge clk);
    reset = 1'b1;

    // A second start with a different amount while busy must not disturb the run.
    push_greedy(55);
    @(negedge clk);
    start = 1'b1; change_in = 7'd55;
    @(negedge clk);
    change_in = 7'd7;
    finish_run(2, 0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("idle_after_busy_start", int'(busy), 0);

`ifdef COIN_STOCK_EN
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(2'd1);
      start_req(7'd5);
      finish_run(1, 0, 1'b0);
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(2'd0);
    start_req(7'd7);
    finish_run(7, 0, 1'b0);

    @(negedge clk);
    start2 = 1'b1; change_in = 7'd3;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    begin
      int coins = 0;
      while (!fault2 && n < 100) begin
        ack2 = 1'b0;
        if (valid2) begin
          check("stock_coin_type", int'(type2), 0);
          coins++;
          ack2 = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      ack2 = 1'b0;
      check("stock_coins", coins, 2);
    end
    check("fault_raised", int'(fault2), 1);
    check("fault_count", int'(count2), 2);
    check("fault_remaining", int'(rem2), 1);
    repeat (3) @(negedge clk);
    check("fault_held", int'(fault2), 1);
    check("fault_busy", int'(busy2), 1);
    #2 reset = 1'b0;
    #1;
    check("fault_cleared", int'(fault2), 0);
    check("fault_busy_cleared", int'(busy2), 0);
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
